// File: rtl/commit_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// commit_ctrl_pkg
//  Shared definitions for the in-order retirement sequencer:
//   - CC_ROB_WIDTH : ROB index width shared with the ROB, RS, LSB and regfile
//   - commit_type_e: encoding of the ROB head entry kind
//   - cc_state_e   : retirement FSM state encoding
// ---------------------------------------------------------------------------
package commit_ctrl_pkg;

  localparam int CC_ROB_WIDTH = 4;

  typedef enum logic [1:0] {
    CT_REG    = 2'd0,
    CT_STORE  = 2'd1,
    CT_BRANCH = 2'd2,
    CT_HALT   = 2'd3
  } commit_type_e;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT_ST = 2'd1,
    S_FLUSH   = 2'd2,
    S_HALT    = 2'd3
  } cc_state_e;

endpackage

// File: rtl/commit_ctrl.sv
// ---------------------------------------------------------------------------
// commit_ctrl
//  In-order retirement sequencer sitting between the ROB head and the
//  architectural state. Each cycle it decides whether the head entry retires,
//  drives the regfile commit port, handshakes stores with the LSB, sequences
//  the mispredict flush/redirect, latches halt and counts retirements.
//
//  Ports
//   clk_in, rst_in           clock, asynchronous active-low reset
//   rdy_in                   global stall: when low nothing advances
//   head_valid/rob_id/type/rd/val/mispred/target
//                            description of the finished ROB head entry
//   pop                      combinational dequeue strobe to the ROB
//   commit_ready/reg_id/val/rob_id
//                            registered regfile commit port
//   store_req/store_rob_id   registered store permission to the LSB
//   store_ack                LSB store-complete pulse
//   clear, redirect_pc       registered global flush pulse and fetch PC
//   halted                   sticky halt flag
//   retire_cnt               retired instruction count (wraps)
// ---------------------------------------------------------------------------
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int ROB_WIDTH = CC_ROB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 head_valid,
  input  logic [ROB_WIDTH-1:0] head_rob_id,
  input  logic [1:0]           head_type,
  input  logic [4:0]           head_rd,
  input  logic [31:0]          head_val,
  input  logic                 head_mispred,
  input  logic [31:0]          head_target,
  output logic                 pop,
  output logic                 commit_ready,
  output logic [4:0]           commit_reg_id,
  output logic [31:0]          commit_val,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 store_req,
  output logic [ROB_WIDTH-1:0] store_rob_id,
  input  logic                 store_ack,
  output logic                 clear,
  output logic [31:0]          redirect_pc,
  output logic                 halted,
  output logic [31:0]          retire_cnt
);

  cc_state_e            state, state_nxt;
  commit_type_e         head_kind;
  logic                 pop_req;
  logic                 commit_ready_nxt;
  logic [4:0]           commit_reg_id_nxt;
  logic [31:0]          commit_val_nxt;
  logic [ROB_WIDTH-1:0] commit_rob_id_nxt;
  logic                 store_req_nxt;
  logic [ROB_WIDTH-1:0] store_rob_id_nxt;
  logic                 clear_nxt;
  logic [31:0]          redirect_pc_nxt;
  logic                 halted_nxt;

  assign head_kind = commit_type_e'(head_type);

  // Stall and reset both suppress the dequeue strobe; the registered side
  // holds on its own via the rdy_in gate in the state register.
  assign pop = pop_req && rdy_in && rst_in;

  always_comb begin
    state_nxt         = state;
    pop_req           = 1'b0;
    commit_ready_nxt  = 1'b0;
    commit_reg_id_nxt = 5'd0;
    commit_val_nxt    = commit_val;
    commit_rob_id_nxt = commit_rob_id;
    store_req_nxt     = store_req;
    store_rob_id_nxt  = store_rob_id;
    clear_nxt         = 1'b0;
    redirect_pc_nxt   = redirect_pc;
    halted_nxt        = halted;

    case (state)
      S_RUN: begin
        // While clear is high the head is being flushed, so it must not retire.
        if (head_valid && !clear) begin
          case (head_kind)
            CT_REG, CT_BRANCH: begin
              pop_req           = 1'b1;
              commit_ready_nxt  = 1'b1;
              commit_reg_id_nxt = head_rd;
              commit_val_nxt    = head_val;
              commit_rob_id_nxt = head_rob_id;
              if (head_kind == CT_BRANCH && head_mispred) begin
                // Link value commits first; clear follows one cycle later
                // because the regfile drops commits while clear is high.
                redirect_pc_nxt = head_target;
                state_nxt       = S_FLUSH;
              end
            end
            CT_STORE: begin
              store_req_nxt    = 1'b1;
              store_rob_id_nxt = head_rob_id;
              state_nxt        = S_WAIT_ST;
            end
            CT_HALT: begin
              pop_req    = 1'b1;
              halted_nxt = 1'b1;
              state_nxt  = S_HALT;
            end
            default: ;
          endcase
        end
      end
      S_WAIT_ST: begin
        if (store_ack) begin
          pop_req       = 1'b1;
          store_req_nxt = 1'b0;
          state_nxt     = S_RUN;
        end
      end
      S_FLUSH: begin
        clear_nxt = 1'b1;
        state_nxt = S_RUN;
      end
      S_HALT: begin
        store_req_nxt = 1'b0;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= S_RUN;
      commit_ready  <= 1'b0;
      commit_reg_id <= 5'd0;
      commit_val    <= 32'd0;
      commit_rob_id <= '0;
      store_req     <= 1'b0;
      store_rob_id  <= '0;
      clear         <= 1'b0;
      redirect_pc   <= 32'd0;
      halted        <= 1'b0;
      retire_cnt    <= 32'd0;
    end else if (rdy_in) begin
      state         <= state_nxt;
      commit_ready  <= commit_ready_nxt;
      commit_reg_id <= commit_reg_id_nxt;
      commit_val    <= commit_val_nxt;
      commit_rob_id <= commit_rob_id_nxt;
      store_req     <= store_req_nxt;
      store_rob_id  <= store_rob_id_nxt;
      clear         <= clear_nxt;
      redirect_pc   <= redirect_pc_nxt;
      halted        <= halted_nxt;
      if (pop_req) retire_cnt <= retire_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_commit_ctrl
//  Directed bench for commit_ctrl. Inputs change 1 time unit after the rising
//  edge; outputs are sampled a further time unit later.
// ---------------------------------------------------------------------------
module tb_commit_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        head_valid;
  logic [3:0]  head_rob_id;
  logic [1:0]  head_type;
  logic [4:0]  head_rd;
  logic [31:0] head_val;
  logic        head_mispred;
  logic [31:0] head_target;
  logic        pop;
  logic        commit_ready;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_val;
  logic [3:0]  commit_rob_id;
  logic        store_req;
  logic [3:0]  store_rob_id;
  logic        store_ack;
  logic        clear;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [31:0] retire_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  commit_ctrl #(.ROB_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .head_valid(head_valid), .head_rob_id(head_rob_id), .head_type(head_type),
    .head_rd(head_rd), .head_val(head_val), .head_mispred(head_mispred),
    .head_target(head_target), .pop(pop), .commit_ready(commit_ready),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val),
    .commit_rob_id(commit_rob_id), .store_req(store_req),
    .store_rob_id(store_rob_id), .store_ack(store_ack), .clear(clear),
    .redirect_pc(redirect_pc), .halted(halted), .retire_cnt(retire_cnt)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_head(input logic v, input logic [3:0] id, input logic [1:0] ty,
                          input logic [4:0] rd, input logic [31:0] val,
                          input logic mis, input logic [31:0] tgt);
    head_valid   = v;
    head_rob_id  = id;
    head_type    = ty;
    head_rd      = rd;
    head_val     = val;
    head_mispred = mis;
    head_target  = tgt;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; store_ack = 1'b0;
    set_head(1'b1, 4'd3, 2'd0, 5'd5, 32'h1234, 1'b0, 32'h0);
    #12;
    n_cmp++; if (pop !== 1'b0) begin n_err++; $display("FAIL reset_pop got %0b want 0", pop); end
    n_cmp++; if ({commit_ready, store_req, clear, halted} !== 4'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 0000", {commit_ready, store_req, clear, halted});
    end
    n_cmp++; if (retire_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", retire_cnt); end
    n_cmp++; if ({commit_reg_id, commit_val, redirect_pc} !== 69'd0) begin
      n_err++; $display("FAIL reset_data got %h want 0", {commit_reg_id, commit_val, redirect_pc});
    end
    head_valid = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    step();
  endtask

  task automatic test_reg();
    set_head(1'b1, 4'd3, 2'd0, 5'd5, 32'h1234, 1'b0, 32'h0);
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_err++; $display("FAIL reg_pop got %0b want 1", pop); end
    step();
    head_valid = 1'b0;
    #1;
    n_cmp++; if (commit_ready !== 1'b1) begin n_err++; $display("FAIL reg_ready got %0b want 1", commit_ready); end
    n_cmp++; if (commit_reg_id !== 5'd5) begin n_err++; $display("FAIL reg_rd got %0d want 5", commit_reg_id); end
    n_cmp++; if (commit_val !== 32'h1234) begin n_err++; $display("FAIL reg_val got %h want 1234", commit_val); end
    n_cmp++; if (commit_rob_id !== 4'd3) begin n_err++; $display("FAIL reg_id got %0d want 3", commit_rob_id); end
    n_cmp++; if (retire_cnt !== 32'd1) begin n_err++; $display("FAIL reg_cnt got %0d want 1", retire_cnt); end
    step();
    n_cmp++; if ({commit_ready, commit_reg_id} !== 6'd0) begin
      n_err++; $display("FAIL reg_idle got %b want 000000", {commit_ready, commit_reg_id});
    end
  endtask

  task automatic test_store();
    set_head(1'b1, 4'd7, 2'd1, 5'd0, 32'h0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (pop !== 1'b0) begin n_err++; $display("FAIL st_pop0 got %0b want 0", pop); end
    step();
    for (int k = 1; k <= 4; k++) begin
      store_ack = (k == 4);
      #1;
      n_cmp++; if (store_req !== 1'b1 || store_rob_id !== 4'd7) begin
        n_err++; $display("FAIL st_req c%0d got %0b/%0d want 1/7", k, store_req, store_rob_id);
      end
      n_cmp++; if (pop !== (k == 4)) begin n_err++; $display("FAIL st_pop c%0d got %0b want %0b", k, pop, (k == 4)); end
      n_cmp++; if (commit_ready !== 1'b0) begin n_err++; $display("FAIL st_commit c%0d got %0b want 0", k, commit_ready); end
      step();
    end
    store_ack = 1'b0;
    head_valid = 1'b0;
    #1;
    n_cmp++; if (store_req !== 1'b0) begin n_err++; $display("FAIL st_drop got %0b want 0", store_req); end
    n_cmp++; if (retire_cnt !== 32'd2) begin n_err++; $display("FAIL st_cnt got %0d want 2", retire_cnt); end
  endtask

  task automatic test_branch();
    set_head(1'b1, 4'd2, 2'd2, 5'd1, 32'h104, 1'b1, 32'h200);
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_err++; $display("FAIL br_pop got %0b want 1", pop); end
    step();
    set_head(1'b1, 4'd4, 2'd0, 5'd9, 32'h55, 1'b0, 32'h0);
    #1;
    n_cmp++; if (commit_ready !== 1'b1 || commit_reg_id !== 5'd1 || commit_val !== 32'h104) begin
      n_err++; $display("FAIL br_link got %0b/%0d/%h want 1/1/104", commit_ready, commit_reg_id, commit_val);
    end
    n_cmp++; if (clear !== 1'b0 || pop !== 1'b0) begin
      n_err++; $display("FAIL br_t1 got clear=%0b pop=%0b want 0/0", clear, pop);
    end
    step();
    n_cmp++; if (clear !== 1'b1 || redirect_pc !== 32'h200) begin
      n_err++; $display("FAIL br_clear got %0b/%h want 1/200", clear, redirect_pc);
    end
    n_cmp++; if (commit_ready !== 1'b0 || pop !== 1'b0) begin
      n_err++; $display("FAIL br_t2 got ready=%0b pop=%0b want 0/0", commit_ready, pop);
    end
    n_cmp++; if (retire_cnt !== 32'd3) begin n_err++; $display("FAIL br_cnt got %0d want 3", retire_cnt); end
    step();
    n_cmp++; if (clear !== 1'b0 || pop !== 1'b1) begin
      n_err++; $display("FAIL br_t3 got clear=%0b pop=%0b want 0/1", clear, pop);
    end
    head_valid = 1'b0;
    step();
  endtask

  task automatic test_rdy_pause();
    set_head(1'b1, 4'd6, 2'd1, 5'd0, 32'h0, 1'b0, 32'h0);
    step();
    rdy_in = 1'b0; store_ack = 1'b1;
    #1;
    n_cmp++; if (pop !== 1'b0) begin n_err++; $display("FAIL rdy_pop got %0b want 0", pop); end
    step();
    store_ack = 1'b0;
    #1;
    n_cmp++; if (store_req !== 1'b1 || retire_cnt !== 32'd3) begin
      n_err++; $display("FAIL rdy_hold got %0b/%0d want 1/3", store_req, retire_cnt);
    end
    rdy_in = 1'b1;
    #1;
    n_cmp++; if (pop !== 1'b0) begin n_err++; $display("FAIL rdy_noack got %0b want 0", pop); end
    step();
    store_ack = 1'b1;
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_err++; $display("FAIL rdy_ackpop got %0b want 1", pop); end
    step();
    store_ack = 1'b0; head_valid = 1'b0;
    #1;
    n_cmp++; if (store_req !== 1'b0 || retire_cnt !== 32'd4) begin
      n_err++; $display("FAIL rdy_done got %0b/%0d want 0/4", store_req, retire_cnt);
    end
  endtask

  task automatic test_reset_in_flush();
    set_head(1'b1, 4'd1, 2'd2, 5'd3, 32'h77, 1'b1, 32'h300);
    step();
    head_valid = 1'b0;
    step();
    n_cmp++; if (clear !== 1'b1) begin n_err++; $display("FAIL rf_pre got %0b want 1", clear); end
    #2;
    rst_in = 1'b0;
    #1;
    n_cmp++; if ({clear, commit_ready, store_req, halted, pop} !== 5'b0) begin
      n_err++; $display("FAIL rf_flags got %b want 00000", {clear, commit_ready, store_req, halted, pop});
    end
    n_cmp++; if (redirect_pc !== 32'd0 || retire_cnt !== 32'd0) begin
      n_err++; $display("FAIL rf_regs got %h/%0d want 0/0", redirect_pc, retire_cnt);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    step();
    set_head(1'b1, 4'd8, 2'd0, 5'd2, 32'hABCD, 1'b0, 32'h0);
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_err++; $display("FAIL rf_run got %0b want 1", pop); end
    step();
    head_valid = 1'b0;
    #1;
    n_cmp++; if (commit_ready !== 1'b1 || commit_val !== 32'hABCD || retire_cnt !== 32'd1) begin
      n_err++; $display("FAIL rf_commit got %0b/%h/%0d want 1/abcd/1", commit_ready, commit_val, retire_cnt);
    end
  endtask

  task automatic test_halt();
    set_head(1'b1, 4'd0, 2'd3, 5'd0, 32'h0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_err++; $display("FAIL ht_pop got %0b want 1", pop); end
    step();
    set_head(1'b1, 4'd1, 2'd0, 5'd4, 32'h99, 1'b0, 32'h0);
    #1;
    n_cmp++; if (halted !== 1'b1 || pop !== 1'b0 || retire_cnt !== 32'd2) begin
      n_err++; $display("FAIL ht_t1 got %0b/%0b/%0d want 1/0/2", halted, pop, retire_cnt);
    end
    step();
    set_head(1'b1, 4'd2, 2'd1, 5'd0, 32'h0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (commit_ready !== 1'b0 || halted !== 1'b1 || pop !== 1'b0) begin
      n_err++; $display("FAIL ht_t2 got %0b/%0b/%0b want 0/1/0", commit_ready, halted, pop);
    end
    step();
    n_cmp++; if (store_req !== 1'b0 || retire_cnt !== 32'd2 || halted !== 1'b1) begin
      n_err++; $display("FAIL ht_t3 got %0b/%0d/%0b want 0/2/1", store_req, retire_cnt, halted);
    end
  endtask

  initial begin
    test_reset();
    test_reg();
    test_store();
    test_branch();
    test_rdy_pause();
    test_reset_in_flush();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
